// File: rtl/vpx_cmd_rx.sv
// vpx_cmd_rx: receive-side deframer for the VPX command lane.
// Collects a 16-symbol DVLD burst (2 bits/symbol, MSB first) into a 32-bit
// word {sync, addr, data, csum}, checks it, and hands good commands to a
// one-deep output register. Saturating statistics counters track outcomes.
//
// Output handshake: a command transfers on any edge where OUT_VLD & OUT_RDY.
// OUT_VLD is a pure register output (no combinational path from OUT_RDY);
// OUT_ADDR/OUT_DATA hold steady while OUT_VLD=1 and OUT_RDY=0.
module vpx_cmd_rx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CMD_DVLD,
  input  logic [1:0]       CMD_DATA,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic [7:0]       OUT_ADDR,
  output logic [7:0]       OUT_DATA,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] FRM_OK_CNT,
  output logic [CNT_W-1:0] ERR_LEN_CNT,
  output logic [CNT_W-1:0] ERR_SYNC_CNT,
  output logic [CNT_W-1:0] ERR_CSUM_CNT,
  output logic [CNT_W-1:0] OVF_CNT,
  output logic [1:0]       STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] shift_q;
  logic [3:0]  cnt_q;
  logic        out_vld_q;
  logic [7:0]  out_addr_q;
  logic [7:0]  out_data_q;

  logic [CNT_W-1:0] ok_cnt_q, len_cnt_q, sync_cnt_q, csum_cnt_q, ovf_cnt_q;

  logic [31:0] shift_d;
  logic [7:0]  csum_exp;
  logic        sync_ok, csum_ok, in_check, frame_good, can_load;
  logic        inc_ok, inc_len, inc_sync, inc_csum, inc_ovf;

  // Next shift value: new symbol enters at the bottom so symbol 0 ends at [31:30].
  assign shift_d  = {shift_q[29:0], CMD_DATA};
  assign csum_exp = ~(shift_q[23:16] + shift_q[15:8]);
  assign sync_ok  = (shift_q[31:24] == SYNC_BYTE);
  assign csum_ok  = (shift_q[7:0] == csum_exp);

  // The CHECK cycle only evaluates when the frame ended cleanly (DVLD low).
  assign in_check   = EN && (state_q == S_CHECK) && !CMD_DVLD;
  assign frame_good = in_check && sync_ok && csum_ok;
  assign can_load   = !out_vld_q || OUT_RDY;

  assign inc_ok   = frame_good;
  assign inc_ovf  = frame_good && !can_load;
  assign inc_sync = in_check && !sync_ok;
  assign inc_csum = in_check && sync_ok && !csum_ok;
  assign inc_len  = EN && (((state_q == S_RECV) && !CMD_DVLD) ||
                           ((state_q == S_CHECK) && CMD_DVLD));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Deframer FSM plus the one-deep output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      if (!EN) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (CMD_DVLD) begin
              shift_q <= shift_d;
              cnt_q   <= 4'd1;
              state_q <= S_RECV;
            end
          end
          S_RECV: begin
            if (CMD_DVLD) begin
              shift_q <= shift_d;
              if (cnt_q == 4'd15) begin
                cnt_q   <= '0;
                state_q <= S_CHECK;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
          S_CHECK: begin
            state_q <= CMD_DVLD ? S_DROP : S_IDLE;
          end
          S_DROP: begin
            if (!CMD_DVLD) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end

      if (frame_good && can_load) begin
        out_vld_q  <= 1'b1;
        out_addr_q <= shift_q[23:16];
        out_data_q <= shift_q[15:8];
      end else if (out_vld_q && OUT_RDY) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ok_cnt_q   <= '0;
      len_cnt_q  <= '0;
      sync_cnt_q <= '0;
      csum_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else if (CNT_CLR) begin
      ok_cnt_q   <= '0;
      len_cnt_q  <= '0;
      sync_cnt_q <= '0;
      csum_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      if (inc_ok)   ok_cnt_q   <= sat_inc(ok_cnt_q);
      if (inc_len)  len_cnt_q  <= sat_inc(len_cnt_q);
      if (inc_sync) sync_cnt_q <= sat_inc(sync_cnt_q);
      if (inc_csum) csum_cnt_q <= sat_inc(csum_cnt_q);
      if (inc_ovf)  ovf_cnt_q  <= sat_inc(ovf_cnt_q);
    end
  end

  assign OUT_VLD      = out_vld_q;
  assign OUT_ADDR     = out_addr_q;
  assign OUT_DATA     = out_data_q;
  assign FRM_OK_CNT   = ok_cnt_q;
  assign ERR_LEN_CNT  = len_cnt_q;
  assign ERR_SYNC_CNT = sync_cnt_q;
  assign ERR_CSUM_CNT = csum_cnt_q;
  assign OVF_CNT      = ovf_cnt_q;
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_vpx_cmd_rx.sv
// Bench for vpx_cmd_rx: burst-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vpx_cmd_rx;

  localparam int         CNT_W = 10;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic             clk, rst, en, dvld, rdy, cnt_clr;
  logic [1:0]       data;
  logic             out_vld;
  logic [7:0]       out_addr, out_data;
  logic [CNT_W-1:0] ok_cnt, len_cnt, sync_cnt, csum_cnt, ovf_cnt;
  logic [1:0]       state_dbg;

  int  total = 0;
  int  bad   = 0;
  bit  checking = 0;
  bit  rand_rdy = 0;

  vpx_cmd_rx #(.SYNC_BYTE(SYNC), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .EN(en), .CMD_DVLD(dvld), .CMD_DATA(data),
    .OUT_VLD(out_vld), .OUT_RDY(rdy), .OUT_ADDR(out_addr), .OUT_DATA(out_data),
    .CNT_CLR(cnt_clr), .FRM_OK_CNT(ok_cnt), .ERR_LEN_CNT(len_cnt),
    .ERR_SYNC_CNT(sync_cnt), .ERR_CSUM_CNT(csum_cnt), .OVF_CNT(ovf_cnt),
    .STATE_DBG(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (burst level) ----------------
  int               m_run;   // symbols seen in current burst, 17 = overlong
  logic [31:0]      m_word;
  logic             m_vld;
  logic [7:0]       m_addr, m_data;
  logic [CNT_W-1:0] m_ok, m_len, m_sync, m_csum, m_ovf;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && v != {CNT_W{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic lerr, serr, cerr, good, ovf;
    logic [7:0] a, d, c;
    lerr = 0; serr = 0; cerr = 0; good = 0; ovf = 0;
    a = m_word[23:16]; d = m_word[15:8]; c = ~(a + d);
    if (rst) begin
      m_run <= 0; m_word <= '0; m_vld <= 0; m_addr <= '0; m_data <= '0;
      m_ok <= '0; m_len <= '0; m_sync <= '0; m_csum <= '0; m_ovf <= '0;
    end else begin
      if (!en) begin
        m_run <= 0;
      end else if (dvld) begin
        if (m_run < 16) begin
          m_word <= {m_word[29:0], data};
          m_run  <= m_run + 1;
        end else if (m_run == 16) begin
          lerr = 1;
          m_run <= 17;
        end
      end else begin
        if (m_run >= 1 && m_run <= 15) lerr = 1;
        else if (m_run == 16) begin
          if (m_word[31:24] != SYNC) serr = 1;
          else if (m_word[7:0] != c) cerr = 1;
          else good = 1;
        end
        m_run <= 0;
      end
      if (good && (!m_vld || rdy)) begin
        m_vld <= 1; m_addr <= a; m_data <= d;
      end else begin
        if (good) ovf = 1;
        if (m_vld && rdy) m_vld <= 0;
      end
      if (cnt_clr) begin
        m_ok <= '0; m_len <= '0; m_sync <= '0; m_csum <= '0; m_ovf <= '0;
      end else begin
        m_ok <= sat(m_ok, good); m_len <= sat(m_len, lerr);
        m_sync <= sat(m_sync, serr); m_csum <= sat(m_csum, cerr);
        m_ovf <= sat(m_ovf, ovf);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_vld", 32'(out_vld), 32'(m_vld));
      chk("cyc_addr", 32'(out_addr), 32'(m_addr));
      chk("cyc_data", 32'(out_data), 32'(m_data));
      chk("cyc_ok", 32'(ok_cnt), 32'(m_ok));
      chk("cyc_len", 32'(len_cnt), 32'(m_len));
      chk("cyc_sync", 32'(sync_cnt), 32'(m_sync));
      chk("cyc_csum", 32'(csum_cnt), 32'(m_csum));
      chk("cyc_ovf", 32'(ovf_cnt), 32'(m_ovf));
    end
  end

  always @(negedge clk) if (rand_rdy) rdy = 1'($urandom_range(0, 1));

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nsym symbols of w (random beyond 16), then one DVLD-low gap cycle.
  task automatic send_word(input logic [31:0] w, input int nsym, input bit gap_rdy);
    for (int k = 0; k < nsym; k++) begin
      @(negedge clk);
      dvld = 1'b1;
      data = (k < 16) ? w[31-2*k -: 2] : 2'($urandom_range(0, 3));
      if (k < 16 && gap_rdy && 0) data = 2'b00;
    end
    @(negedge clk);
    dvld = 1'b0;
    if (gap_rdy) rdy = 1'b1;
  endtask

  task automatic clr_counters();
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] c;
    c = ~(a + d);
    return {s, a, d, c};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; en = 1; dvld = 0; data = 0; rdy = 1; cnt_clr = 0;
    idle(3);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_ok", 32'(ok_cnt), 0);
    chk("rst_len", 32'(len_cnt), 0);
    rst = 0;
    checking = 1;
    idle(2);

    // Good frame, consumer ready: one-cycle pulse
    send_word(32'hA51234B9, 16, 0);
    @(negedge clk);
    chk("good_vld", 32'(out_vld), 1);
    chk("good_addr", 32'(out_addr), 32'h12);
    chk("good_data", 32'(out_data), 32'h34);
    chk("good_ok", 32'(ok_cnt), 1);
    @(negedge clk);
    chk("good_pulse_end", 32'(out_vld), 0);

    // Checksum error, then sync error (sync wins)
    send_word(32'hA5123400, 16, 0); idle(2);
    chk("csum_cnt", 32'(csum_cnt), 1);
    chk("csum_novld", 32'(out_vld), 0);
    send_word(32'h5A1234B9, 16, 0); idle(2);
    chk("sync_cnt", 32'(sync_cnt), 1);
    chk("sync_csum_cnt", 32'(csum_cnt), 1);

    // Short and long bursts, then a good frame right after the long one
    clr_counters();
    send_word(32'hA51234B9, 10, 0); idle(2);
    chk("short_len", 32'(len_cnt), 1);
    chk("short_idle", 32'(state_dbg), 0);
    send_word(32'hA51234B9, 20, 0);
    send_word(32'hA5567831, 16, 0);
    @(negedge clk);
    chk("long_len", 32'(len_cnt), 2);
    chk("after_long_vld", 32'(out_vld), 1);
    chk("after_long_addr", 32'(out_addr), 32'h56);
    chk("after_long_ok", 32'(ok_cnt), 1);
    idle(2);

    // Overflow while the consumer stalls
    clr_counters();
    rdy = 0;
    send_word(mk(SYNC, 8'h01, 8'h02), 16, 0);
    send_word(mk(SYNC, 8'h03, 8'h04), 16, 0);
    idle(2);
    chk("ovf_vld", 32'(out_vld), 1);
    chk("ovf_addr", 32'(out_addr), 32'h01);
    chk("ovf_data", 32'(out_data), 32'h02);
    chk("ovf_cnt", 32'(ovf_cnt), 1);
    chk("ovf_ok", 32'(ok_cnt), 2);
    rdy = 1;
    @(negedge clk); rdy = 0;
    chk("ovf_drain", 32'(out_vld), 0);

    // Ready exactly in the CHECK cycle of the second frame
    clr_counters();
    send_word(mk(SYNC, 8'h01, 8'h02), 16, 0);
    idle(1);
    send_word(mk(SYNC, 8'h03, 8'h04), 16, 1);
    @(negedge clk); rdy = 0;
    chk("chk_rdy_vld", 32'(out_vld), 1);
    chk("chk_rdy_addr", 32'(out_addr), 32'h03);
    chk("chk_rdy_data", 32'(out_data), 32'h04);
    chk("chk_rdy_ovf", 32'(ovf_cnt), 0);
    rdy = 1; idle(2);

    // Enable dropped at symbol 8
    clr_counters();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dvld = 1; en = (k < 8); data = 2'($urandom_range(0, 3));
    end
    @(negedge clk); dvld = 0; en = 1;
    idle(2);
    chk("en_len", 32'(len_cnt), 0);
    chk("en_ok", 32'(ok_cnt), 0);
    chk("en_vld", 32'(out_vld), 0);

    // Asynchronous reset mid-frame with pending output and nonzero counters
    rdy = 0;
    send_word(32'hA51234B9, 16, 0); idle(1);
    send_word(32'hA51234B9, 8, 0);
    @(negedge clk); dvld = 1;
    @(posedge clk); #2 rst = 1;
    #1;
    chk("arst_vld", 32'(out_vld), 0);
    chk("arst_addr", 32'(out_addr), 0);
    chk("arst_ok", 32'(ok_cnt), 0);
    @(negedge clk); rst = 0; dvld = 0; rdy = 1;
    idle(2);

    // Saturation and clear
    clr_counters();
    repeat ((1 << CNT_W) + 4) begin
      @(negedge clk); dvld = 1; data = 2'b11;
      @(negedge clk); dvld = 0;
    end
    idle(1);
    chk("sat_len", 32'(len_cnt), (1 << CNT_W) - 1);
    clr_counters();
    chk("sat_clr", 32'(len_cnt), 0);

    // Randomized traffic
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [31:0] w;
      kind = $urandom_range(0, 9);
      w = mk(SYNC, 8'($urandom), 8'($urandom));
      case (kind)
        0, 1, 2, 3: send_word(w, 16, 0);
        4: send_word(w ^ 32'(8'($urandom_range(1, 255))), 16, 0);
        5: send_word(w ^ {8'($urandom_range(1, 255)), 24'h0}, 16, 0);
        6: send_word(w, $urandom_range(1, 15), 0);
        7: send_word(w, $urandom_range(17, 20), 0);
        8: begin
          int cut;
          cut = $urandom_range(0, 15);
          for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            dvld = 1; en = (k < cut); data = w[31-2*k -: 2];
          end
          @(negedge clk); dvld = 0; en = 1;
        end
        default: begin
          @(negedge clk); cnt_clr = 1;
          @(negedge clk); cnt_clr = 0;
        end
      endcase
      idle($urandom_range(0, 2));
    end
    rand_rdy = 0;
    rdy = 1;
    idle(4);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
